// File: rtl/dla_regif_apb_pkg.sv
// Register map, FSM states and GO bit layout shared by the DLA APB register interface.
package PKG_dla_regmap;

    localparam int unsigned OFF_GLB_STATUS     = 'h000;
    localparam int unsigned OFF_GLB_INTR       = 'h004;
    localparam int unsigned OFF_GLB_ENABLE_ROW = 'h008;
    localparam int unsigned OFF_GLB_ENABLE_COL = 'h00C;
    localparam int unsigned OFF_COMP_PRECISION = 'h010;
    localparam int unsigned OFF_GLB_GO         = 'h020;
    localparam int unsigned OFF_VERSION        = 'h0FC;

    // Bit positions inside the decoder's one-hot select vector
    localparam int NUM_SEL     = 7;
    localparam int SEL_STATUS  = 0;
    localparam int SEL_INTR    = 1;
    localparam int SEL_ROW     = 2;
    localparam int SEL_COL     = 3;
    localparam int SEL_PREC    = 4;
    localparam int SEL_GO      = 5;
    localparam int SEL_VERSION = 6;

    localparam int GO_W           = 6;
    localparam int GO_MOV_DDR2GB  = 0;
    localparam int GO_MOV_GB2LB   = 1;
    localparam int GO_COMP_CONV   = 2;
    localparam int GO_COMP_FC     = 3;
    localparam int GO_COMP_APE    = 4;
    localparam int GO_COMP_RESHAPE = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    function automatic logic is_onehot6(input logic [GO_W-1:0] v);
        return (v != '0) && ((v & (v - 6'd1)) == '0);
    endfunction

endpackage

// File: rtl/dla_regif_apb_dec.sv
// Combinational address decoder: word address to one-hot register select plus hit flag.
module dla_regif_apb_dec
    import PKG_dla_regmap::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-3:0]  waddr,
    output logic [NUM_SEL-1:0] sel,
    output logic               valid
);

    logic [ADDR_W-1:0] byte_addr;

    assign byte_addr = {waddr, 2'b00};

    always_comb begin
        sel              = '0;
        sel[SEL_STATUS]  = (byte_addr == ADDR_W'(OFF_GLB_STATUS));
        sel[SEL_INTR]    = (byte_addr == ADDR_W'(OFF_GLB_INTR));
        sel[SEL_ROW]     = (byte_addr == ADDR_W'(OFF_GLB_ENABLE_ROW));
        sel[SEL_COL]     = (byte_addr == ADDR_W'(OFF_GLB_ENABLE_COL));
        sel[SEL_PREC]    = (byte_addr == ADDR_W'(OFF_COMP_PRECISION));
        sel[SEL_GO]      = (byte_addr == ADDR_W'(OFF_GLB_GO));
        sel[SEL_VERSION] = (byte_addr == ADDR_W'(OFF_VERSION));
    end

    assign valid = |sel;

endmodule

// File: rtl/dla_regif_apb.sv
// APB3 slave front-end for the DLA register file: zero-wait writes, one-wait reads,
// one-cycle write strobes and guarded operation launch pulses.
module dla_regif_apb
    import PKG_dla_regmap::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] VERSION = 32'h0003_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [31:0]       glb_status_rdata,
    input  logic [31:0]       glb_intr_rdata,
    input  logic [31:0]       glb_enable_row_rdata,
    input  logic [31:0]       glb_enable_col_rdata,
    input  logic [31:0]       comp_precision_rdata,
    output logic              glb_intr_wen,
    output logic              glb_enable_row_wen,
    output logic              glb_enable_col_wen,
    output logic              comp_precision_wen,
    output logic [31:0]       regif_wdata,
    output logic              go_mov_ddr2gb,
    output logic              go_mov_gb2lb,
    output logic              go_comp_conv,
    output logic              go_comp_fc,
    output logic              go_comp_ape,
    output logic              go_comp_reshape
);

    state_t             state, state_nxt;
    logic [NUM_SEL-1:0] sel;
    logic               addr_ok;
    logic [31:0]        rd_mux;
    logic [31:0]        rd_data_q;
    logic               rd_err_q;
    logic [3:0]         wen_q;
    logic [GO_W-1:0]    go_q;
    logic               busy_hold;
    logic [1:0]         busy_cnt;
    logic               access, idle, go_ok, wr_err, wr_ok, rd_fire;

    dla_regif_apb_dec #(.ADDR_W(ADDR_W)) u_dec (
        .waddr (paddr[ADDR_W-1:2]),
        .sel   (sel),
        .valid (addr_ok)
    );

    assign access  = psel & penable;
    assign idle    = (state == ST_IDLE);
    assign go_ok   = is_onehot6(pwdata[GO_W-1:0]) && (glb_status_rdata[GO_W-1:0] == '0) && !busy_hold;
    assign wr_err  = !addr_ok | sel[SEL_STATUS] | sel[SEL_VERSION] | (sel[SEL_GO] & !go_ok);
    assign wr_ok   = idle & access & pwrite & !wr_err;
    assign rd_fire = idle & access & !pwrite;

    // GO and unmapped addresses read back as zero
    always_comb begin
        rd_mux = '0;
        if (sel[SEL_STATUS])  rd_mux = glb_status_rdata;
        if (sel[SEL_INTR])    rd_mux = glb_intr_rdata;
        if (sel[SEL_ROW])     rd_mux = glb_enable_row_rdata;
        if (sel[SEL_COL])     rd_mux = glb_enable_col_rdata;
        if (sel[SEL_PREC])    rd_mux = comp_precision_rdata;
        if (sel[SEL_VERSION]) rd_mux = VERSION;
    end

    always_comb begin
        state_nxt = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (pwrite) begin
                            pready  = 1'b1;
                            pslverr = wr_err;
                        end else begin
                            state_nxt = ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    pready    = 1'b1;
                    prdata    = rd_data_q;
                    pslverr   = rd_err_q;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // busy_hold covers the launch cycle plus three more unless status reports activity sooner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            wen_q       <= '0;
            go_q        <= '0;
            regif_wdata <= '0;
            busy_hold   <= 1'b0;
            busy_cnt    <= '0;
        end else begin
            state <= state_nxt;
            wen_q <= '0;
            go_q  <= '0;
            if (rd_fire) begin
                rd_data_q <= rd_mux;
                rd_err_q  <= !addr_ok;
            end
            if (wr_ok && !sel[SEL_GO]) begin
                wen_q       <= {sel[SEL_PREC], sel[SEL_COL], sel[SEL_ROW], sel[SEL_INTR]};
                regif_wdata <= pwdata;
            end
            if (wr_ok && sel[SEL_GO]) begin
                go_q      <= pwdata[GO_W-1:0];
                busy_hold <= 1'b1;
                busy_cnt  <= '0;
            end else if (busy_hold) begin
                if ((glb_status_rdata[GO_W-1:0] != '0) || (busy_cnt == 2'd3)) begin
                    busy_hold <= 1'b0;
                end
                busy_cnt <= busy_cnt + 2'd1;
            end
        end
    end

    assign glb_intr_wen       = wen_q[0];
    assign glb_enable_row_wen = wen_q[1];
    assign glb_enable_col_wen = wen_q[2];
    assign comp_precision_wen = wen_q[3];

    assign go_mov_ddr2gb   = go_q[GO_MOV_DDR2GB];
    assign go_mov_gb2lb    = go_q[GO_MOV_GB2LB];
    assign go_comp_conv    = go_q[GO_COMP_CONV];
    assign go_comp_fc      = go_q[GO_COMP_FC];
    assign go_comp_ape     = go_q[GO_COMP_APE];
    assign go_comp_reshape = go_q[GO_COMP_RESHAPE];

endmodule

// File: doc/dla_regif_apb.md
DLA_REGIF_APB -- requirements
Module: dla_regif_apb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning APB address width in bits.
REQ-002 SHALL have parameter VERSION, default 32'h0003_0001, meaning the constant returned by register VERSION.
REQ-003 SHALL have the following ports; clock is clk, reset is rst_n, one clock, and rst_n is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- psel, penable, pwrite  in  1 each  APB3 request
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- prdata  out  32  read data
- pready, pslverr  out  1 each  APB3 response
- glb_status_rdata, glb_intr_rdata, glb_enable_row_rdata, glb_enable_col_rdata, comp_precision_rdata  in  32 each  register read-back
- glb_intr_wen, glb_enable_row_wen, glb_enable_col_wen, comp_precision_wen  out  1 each  write strobes
- regif_wdata  out  32  write data to register file
- go_mov_ddr2gb, go_mov_gb2lb, go_comp_conv, go_comp_fc, go_comp_ape, go_comp_reshape  out  1 each  operation launch pulses

Function
REQ-004 SHALL decode paddr[ADDR_W-1:2] with this map: 0x000 GLB_STATUS (RO), 0x004 GLB_INTR (RW), 0x008 GLB_ENABLE_ROW (RW), 0x00C GLB_ENABLE_COL (RW), 0x010 COMP_PRECISION (RW), 0x020 GLB_GO (WO; reads 0), 0x0FC VERSION (RO); paddr[1:0] is ignored.
REQ-005 SHALL run a 3-state FSM: IDLE, RD_WAIT, RESP.
REQ-006 From IDLE with psel&penable, SHALL complete a write in that cycle (pready=1) and stay in IDLE.
REQ-007 From IDLE with psel&penable&!pwrite, SHALL drive pready=0, register the decoded read data, and go to RD_WAIT.
REQ-008 In RD_WAIT, SHALL drive pready=1 with the registered prdata and pslverr, then return to IDLE; reads therefore have exactly one wait state.
REQ-009 prdata SHALL be 0 whenever pready=0 or the transfer is a write.
REQ-010 SHALL raise pslverr with pready for: an unmapped address, a write to GLB_STATUS or VERSION, or a rejected GLB_GO write (REQ-014); an erroring access SHALL produce no strobe and no go pulse.
REQ-011 An accepted write to a RW register SHALL assert the matching *_wen for exactly one cycle, in the cycle after completion, with regif_wdata = pwdata registered in that same cycle.
REQ-012 regif_wdata SHALL hold its last value when no strobe is asserted.
REQ-013 An accepted GLB_GO write SHALL assert the go_* output selected by pwdata[5:0] (bit0 ddr2gb, bit1 gb2lb, bit2 conv, bit3 fc, bit4 ape, bit5 reshape) for exactly one cycle, in the cycle after completion.
REQ-014 SHALL reject a GLB_GO write when pwdata[5:0] is not one-hot, when glb_status_rdata[5:0] != 0, or when busy_hold is set.
REQ-015 busy_hold SHALL set on any go pulse and clear when glb_status_rdata[5:0] becomes nonzero or after 4 cycles, whichever comes first.
REQ-016 At most one *_wen or go_* output SHALL be high in any cycle.
REQ-017 psel deasserted mid-RD_WAIT SHALL still return the FSM to IDLE after one cycle, with no side effects.
REQ-018 A read in the first transfer after a write SHALL return the updated value.

Reset
REQ-019 While rst_n=0 at a clk edge: the FSM SHALL enter IDLE; pready, pslverr, prdata, every *_wen, regif_wdata and every go_* SHALL be 0; busy_hold SHALL clear.
REQ-020 A reset during RD_WAIT SHALL abort the read without a response.

Structure
REQ-021 Register offsets, the FSM state enum, and the GO bit indices SHALL live in PKG_dla_regmap.
REQ-022 Address decode SHALL be a single sub-module, dla_regif_apb_dec: combinational, mapping address to one-hot select plus a valid flag.

Verification
REQ-023 Write 0x0000_00F0 to 0x008 -> glb_enable_row_wen=1 for one cycle the next cycle, regif_wdata=0x0000_00F0, pslverr=0.
REQ-024 Read 0x0FC -> pready low for 1 cycle, then prdata=32'h0003_0001, pslverr=0.
REQ-025 Write 0x04 to 0x020 with status 0 -> go_comp_conv pulses once; an immediate second GO write -> pslverr=1, no pulse.
REQ-026 Write 0x06 to 0x020 -> pslverr=1, no go pulse; write to 0x000 -> pslverr=1, no strobe.
REQ-027 Read 0x044 -> prdata=0, pslverr=1.
REQ-028 Assert rst_n=0 during RD_WAIT -> next cycle pready=0, FSM in IDLE, all outputs 0.
